proton_mem_arbiter: RTL and testbench
=====================================

# proton_mem_arbiter

Single-port RAM arbiter for the PROTON RV32I core. The instruction-fetch (IF) and load/store (MEM) stages share one unified instruction/data RAM, and this block decides which stage owns the port each cycle. It registers the winning request onto the RAM port, returns read data one cycle later, and prevents fetch starvation under sustained load/store traffic.

## Interface
Parameters:
- AW, 10, RAM word-address width
- DW, 32, data width
- STARVE_LIMIT, 4, number of consecutive denied IF-request cycles after which IF wins (1..15)

Ports:
- CLK1  in  1  sole clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- IF_REQ  in  1  fetch request
- IF_ADDR  in  AW  fetch word address
- IF_GNT  out  1  fetch granted (RAM port driven for IF this cycle)
- IF_RVALID  out  1  fetch data valid
- IF_RDATA  out  DW  fetch data
- MEM_REQ  in  1  load/store request
- MEM_WE  in  1  1 = store, 0 = load
- MEM_ADDR  in  AW  load/store word address
- MEM_WDATA  in  DW  store data
- MEM_GNT  out  1  load/store granted
- MEM_RVALID  out  1  load data valid (never set for stores)
- MEM_RDATA  out  DW  load data
- RAM_EN, RAM_WE  out  1 each  RAM port enable and write enable
- RAM_ADDR  out  AW  RAM address
- RAM_WDATA  out  DW  RAM write data
- RAM_RDATA  in  DW  RAM read data, valid the cycle after RAM_EN with RAM_WE=0
- CONFLICT_CNT  out  16  saturating count of cycles in which both requests were sampled high

## Operation
- Requests are sampled at each rising edge. A requester holds REQ and its address/data stable until it sees GNT.
- REQ still high during a GNT cycle counts as a new request, using the address/data current in that cycle. This allows back-to-back grants.
- Arbitration per sampled edge:
  - Only one REQ high: that requester wins.
  - Both high: MEM wins unless STARVE_CNT ≥ STARVE_LIMIT, in which case IF wins.
  - Neither high: the port is idle.
- STARVE_CNT is 4 bits:
  - Increments, saturating at 15, on each edge where IF_REQ is sampled high and IF loses.
  - Clears when IF wins or when IF_REQ is sampled low.
- The winner is registered into OWNER (NONE/IF/MEM) together with RAM_EN, RAM_WE, RAM_ADDR and RAM_WDATA. IF grants force RAM_WE=0 and RAM_WDATA=0.
- x_GNT = (OWNER == x), decoded from the register.
- Response:
  - A read granted in cycle G sets x_RVALID=1 in cycle G+1 (RVALID is registered from OWNER and ~RAM_WE).
  - x_RDATA passes RAM_RDATA through whenever x_RVALID=1 and is 0 otherwise.
- CONFLICT_CNT increments on each edge where IF_REQ and MEM_REQ are both sampled high, and saturates at 0xFFFF.

## Timing
- Reset values: every output, OWNER, STARVE_CNT and the round-robin pointer are 0 (pointer value 0 means IF was last granted).
- Latency: REQ sampled at edge E → GNT and RAM_* in cycle E+1 → RVALID and RDATA in cycle E+2.
- Throughput: one RAM access per cycle.
- RST high overrides everything:
  - Outputs are 0 in the cycle after the RST edge.
  - An RVALID owed for a grant issued just before reset is suppressed.
  - Requests sampled on an RST edge are discarded.
- First possible grant: the cycle after the first edge with RST low.
- An IF write is impossible by construction. MEM_WE is ignored while MEM_REQ is low.
- STARVE_LIMIT ≥ 1 is required. Behaviour with 0 is undefined.

## Configuration
- PROTON_ARB_RR_EN defined: both-high conflicts go to the requester not granted most recently (tracked by a 1-bit pointer). STARVE_CNT and STARVE_LIMIT logic are removed.
- PROTON_ARB_RR_EN undefined: MEM-priority with starvation limit, as above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset: RST high 2 cycles with both REQ high → all outputs 0 throughout. The first GNT appears on the second cycle after RST falls.
- IF read: IF_REQ=1, IF_ADDR=0x004 at edge 0, RAM[4]=0x00010233 → cycle 1: IF_GNT=1, RAM_EN=1, RAM_WE=0, RAM_ADDR=0x004; cycle 2: IF_RVALID=1, IF_RDATA=0x00010233.
- Store: MEM_REQ=1, MEM_WE=1, MEM_ADDR=0x010, MEM_WDATA=0xDEADBEEF → cycle 1: MEM_GNT=1, RAM_WE=1, RAM_WDATA=0xDEADBEEF; MEM_RVALID stays 0.
- Starvation (STARVE_LIMIT=4): both REQ high for 10 edges → grants run MEM×4, IF, MEM×4, IF; CONFLICT_CNT=10.
- Reset mid-op: RST asserted during an IF_GNT read cycle → next cycle IF_RVALID=0, RAM_EN=0, CONFLICT_CNT=0.
- With PROTON_ARB_RR_EN: both REQ high continuously → grants alternate MEM, IF, MEM, IF… with MEM first after reset.

Source files
------------

// File: rtl/proton_mem_arbiter_if.sv
// Shared bus between IF/MEM requesters, the unified RAM and the arbiter.
// The slave modport is the arbiter side; master is the requester/RAM side.
interface proton_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          IF_REQ;
    logic [AW-1:0] IF_ADDR;
    logic          IF_GNT;
    logic          IF_RVALID;
    logic [DW-1:0] IF_RDATA;
    logic          MEM_REQ;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_GNT;
    logic          MEM_RVALID;
    logic [DW-1:0] MEM_RDATA;
    logic          RAM_EN;
    logic          RAM_WE;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_WDATA;
    logic [DW-1:0] RAM_RDATA;
    logic [15:0]   CONFLICT_CNT;

    modport slave (
        input  IF_REQ, IF_ADDR,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  RAM_RDATA,
        output IF_GNT, IF_RVALID, IF_RDATA,
        output MEM_GNT, MEM_RVALID, MEM_RDATA,
        output RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA,
        output CONFLICT_CNT
    );

    modport master (
        output IF_REQ, IF_ADDR,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output RAM_RDATA,
        input  IF_GNT, IF_RVALID, IF_RDATA,
        input  MEM_GNT, MEM_RVALID, MEM_RDATA,
        input  RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA,
        input  CONFLICT_CNT
    );
endinterface

// File: rtl/proton_mem_arbiter.sv
// IF/MEM arbiter for the PROTON unified single-port RAM.
// Define PROTON_ARB_RR_EN for round-robin conflicts instead of MEM priority.
module proton_mem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 CLK1,
    input  logic                 RST,
    proton_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    owner_t        owner;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          if_rvalid;
    logic          mem_rvalid;
    logic [15:0]   conflict_cnt;

    logic both;
    logic if_only;
    logic mem_only;
    logic win_if;
    logic win_mem;

    assign both     = bus.IF_REQ & bus.MEM_REQ;
    assign if_only  = bus.IF_REQ & ~bus.MEM_REQ;
    assign mem_only = bus.MEM_REQ & ~bus.IF_REQ;

`ifdef PROTON_ARB_RR_EN
    // 0: IF was granted last, 1: MEM was granted last
    logic rr_ptr;
    logic conf_if;

    assign conf_if = rr_ptr;
`else
    logic [3:0] starve_cnt;
    logic       conf_if;

    assign conf_if = starve_cnt >= 4'(STARVE_LIMIT);
`endif

    always_comb begin
        win_if  = 1'b0;
        win_mem = 1'b0;
        unique case (1'b1)
            both: begin
                win_if  = conf_if;
                win_mem = ~conf_if;
            end
            if_only:  win_if  = 1'b1;
            mem_only: win_mem = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK1) begin
        if (RST) begin
            owner        <= OWN_NONE;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            if_rvalid    <= 1'b0;
            mem_rvalid   <= 1'b0;
            conflict_cnt <= '0;
`ifdef PROTON_ARB_RR_EN
            rr_ptr       <= 1'b0;
`else
            starve_cnt   <= '0;
`endif
        end else begin
            if_rvalid  <= (owner == OWN_IF) & ~ram_we;
            mem_rvalid <= (owner == OWN_MEM) & ~ram_we;

            if (both && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;

            unique case (1'b1)
                win_if: begin
                    owner     <= OWN_IF;
                    ram_en    <= 1'b1;
                    ram_we    <= 1'b0;
                    ram_addr  <= bus.IF_ADDR;
                    ram_wdata <= '0;
                end
                win_mem: begin
                    owner     <= OWN_MEM;
                    ram_en    <= 1'b1;
                    ram_we    <= bus.MEM_WE;
                    ram_addr  <= bus.MEM_ADDR;
                    ram_wdata <= bus.MEM_WDATA;
                end
                default: begin
                    owner     <= OWN_NONE;
                    ram_en    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_addr  <= '0;
                    ram_wdata <= '0;
                end
            endcase

`ifdef PROTON_ARB_RR_EN
            if (win_if)
                rr_ptr <= 1'b0;
            else if (win_mem)
                rr_ptr <= 1'b1;
`else
            if (!bus.IF_REQ || win_if)
                starve_cnt <= '0;
            else if (starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 4'd1;
`endif
        end
    end

    assign bus.IF_GNT       = (owner == OWN_IF);
    assign bus.MEM_GNT      = (owner == OWN_MEM);
    assign bus.IF_RVALID    = if_rvalid;
    assign bus.MEM_RVALID   = mem_rvalid;
    assign bus.IF_RDATA     = if_rvalid ? bus.RAM_RDATA : '0;
    assign bus.MEM_RDATA    = mem_rvalid ? bus.RAM_RDATA : '0;
    assign bus.RAM_EN       = ram_en;
    assign bus.RAM_WE       = ram_we;
    assign bus.RAM_ADDR     = ram_addr;
    assign bus.RAM_WDATA    = ram_wdata;
    assign bus.CONFLICT_CNT = conflict_cnt;
endmodule

// File: tb/tb_proton_mem_arbiter.sv
// Directed-vector bench for proton_mem_arbiter with a behavioural RAM.
// Inputs change after the falling edge; outputs are sampled at the next one.
module tb_proton_mem_arbiter;
    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [9:0]  iaddr;
        logic        mreq;
        logic        mwe;
        logic [9:0]  maddr;
        logic [31:0] mwdata;
    } in_t;

    typedef struct packed {
        logic        ignt;
        logic        mgnt;
        logic        irv;
        logic        mrv;
        logic [31:0] irdata;
        logic [31:0] mrdata;
        logic        en;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nmis;

    proton_mem_arbiter_if #(.AW(10), .DW(32)) bus ();

    proton_mem_arbiter #(
        .AW(10),
        .DW(32),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK1(clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [0:1023];

    always @(posedge clk) begin
        if (rst) begin
            ram[10'h004] <= 32'h0001_0233;
            ram[10'h008] <= 32'h1111_2222;
            ram[10'h020] <= 32'hCAFE_F00D;
            ram[10'h021] <= 32'h0BAD_C0DE;
        end else if (bus.RAM_EN) begin
            if (bus.RAM_WE)
                ram[bus.RAM_ADDR] <= bus.RAM_WDATA;
            else
                bus.RAM_RDATA <= ram[bus.RAM_ADDR];
        end
    end

    function automatic in_t vi(logic r, logic ir, logic [9:0] ia,
                               logic mr, logic mw, logic [9:0] ma,
                               logic [31:0] md);
        in_t v;
        v.rst = r; v.ireq = ir; v.iaddr = ia;
        v.mreq = mr; v.mwe = mw; v.maddr = ma; v.mwdata = md;
        return v;
    endfunction

    function automatic out_t mo(logic ig, logic mg, logic irv, logic mrv,
                                logic [31:0] ird, logic [31:0] mrd,
                                logic en, logic we, logic [9:0] a,
                                logic [31:0] wd, logic [15:0] c);
        out_t o;
        o.ignt = ig; o.mgnt = mg; o.irv = irv; o.mrv = mrv;
        o.irdata = ird; o.mrdata = mrd; o.en = en; o.we = we;
        o.addr = a; o.wdata = wd; o.cnt = c;
        return o;
    endfunction

    function automatic out_t sample();
        return mo(bus.IF_GNT, bus.MEM_GNT, bus.IF_RVALID, bus.MEM_RVALID,
                  bus.IF_RDATA, bus.MEM_RDATA, bus.RAM_EN, bus.RAM_WE,
                  bus.RAM_ADDR, bus.RAM_WDATA, bus.CONFLICT_CNT);
    endfunction

    task automatic step(input in_t v);
        rst           = v.rst;
        bus.IF_REQ    = v.ireq;
        bus.IF_ADDR   = v.iaddr;
        bus.MEM_REQ   = v.mreq;
        bus.MEM_WE    = v.mwe;
        bus.MEM_ADDR  = v.maddr;
        bus.MEM_WDATA = v.mwdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input out_t exp);
        out_t act;
        act = sample();
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_gnt(input string name, input logic ig,
                           input logic mg, input logic [15:0] c);
        logic [17:0] act;
        logic [17:0] exp;
        act = {bus.IF_GNT, bus.MEM_GNT, bus.CONFLICT_CNT};
        exp = {ig, mg, c};
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got gnt/cnt %h expected %h", name, act, exp);
        end
    endtask

    vec_t        tbl [11];
    logic [9:0]  if_pat;
    in_t         both_rd;
    in_t         idle;

    initial begin
        nvec = 0;
        nmis = 0;
        rst = 1'b1;
        bus.IF_REQ = 1'b0;
        bus.IF_ADDR = '0;
        bus.MEM_REQ = 1'b0;
        bus.MEM_WE = 1'b0;
        bus.MEM_ADDR = '0;
        bus.MEM_WDATA = '0;

        idle = vi(0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = '{vi(1, 1, 10'h004, 1, 0, 10'h008, 0),
                    mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{vi(1, 1, 10'h004, 1, 0, 10'h008, 0),
                    mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{vi(0, 1, 10'h004, 1, 0, 10'h008, 0),
                    mo(0, 1, 0, 0, 0, 0, 1, 0, 10'h008, 0, 1)};
        tbl[3]  = '{vi(0, 1, 10'h004, 0, 0, 0, 0),
                    mo(1, 0, 0, 1, 0, 32'h1111_2222, 1, 0, 10'h004, 0, 1)};
        tbl[4]  = '{idle,
                    mo(0, 0, 1, 0, 32'h0001_0233, 0, 0, 0, 0, 0, 1)};
        tbl[5]  = '{vi(0, 0, 0, 1, 1, 10'h010, 32'hDEAD_BEEF),
                    mo(0, 1, 0, 0, 0, 0, 1, 1, 10'h010, 32'hDEAD_BEEF, 1)};
        tbl[6]  = '{vi(0, 0, 0, 1, 0, 10'h010, 0),
                    mo(0, 1, 0, 0, 0, 0, 1, 0, 10'h010, 0, 1)};
        tbl[7]  = '{vi(0, 0, 0, 0, 1, 0, 0),
                    mo(0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 1)};
        tbl[8]  = '{vi(0, 1, 10'h020, 0, 0, 0, 0),
                    mo(1, 0, 0, 0, 0, 0, 1, 0, 10'h020, 0, 1)};
        tbl[9]  = '{vi(0, 1, 10'h021, 0, 0, 0, 0),
                    mo(1, 0, 1, 0, 32'hCAFE_F00D, 0, 1, 0, 10'h021, 0, 1)};
        tbl[10] = '{idle,
                    mo(0, 0, 1, 0, 32'h0BAD_C0DE, 0, 0, 0, 0, 0, 1)};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].i);
            chk_out($sformatf("vec%0d", i), tbl[i].o);
        end

        // sustained conflict: bit i set means IF wins on that edge
`ifdef PROTON_ARB_RR_EN
        if_pat = 10'b10_1010_1010;
`else
        if_pat = 10'b10_0001_0000;
`endif
        both_rd = vi(0, 1, 10'h004, 1, 0, 10'h008, 0);
        for (int i = 0; i < 10; i++) begin
            step(both_rd);
            chk_gnt($sformatf("starve%0d", i), if_pat[i], ~if_pat[i],
                    16'(2 + i));
        end

        step(vi(0, 1, 10'h004, 0, 0, 0, 0));
        chk_gnt("pre_rst_if", 1'b1, 1'b0, 16'd11);

        step(vi(1, 1, 10'h004, 1, 0, 10'h008, 0));
        chk_out("mid_rst", mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        step(vi(0, 1, 10'h008, 0, 0, 0, 0));
        chk_out("post_rst_gnt",
                mo(1, 0, 0, 0, 0, 0, 1, 0, 10'h008, 0, 0));

        step(idle);
        chk_out("post_rst_rd",
                mo(0, 0, 1, 0, 32'h1111_2222, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
